// File: rtl/gust_pkg.sv
// Shared constants and FSM encoding for the GUST sparse matrix-vector engine.
package gust_pkg;
  localparam int DEF_LANES   = 16;
  localparam int DEF_ROWS    = 16;
  localparam int DEF_VALUE_W = 32;
  localparam int DEF_INDEX_W = 5;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;
endpackage

// File: rtl/gust_lane_mult.sv
// One multiplier lane: registers the truncated product with its row index and a valid flag.
module gust_lane_mult #(
  parameter int VALUE_W = 32,
  parameter int INDEX_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [VALUE_W-1:0] val,
  input  logic [VALUE_W-1:0] vec_val,
  input  logic [INDEX_W-1:0] ind,
  output logic [VALUE_W-1:0] prod,
  output logic [INDEX_W-1:0] prod_ind,
  output logic               prod_valid
);

  // Low VALUE_W bits of the product are identical for signed and unsigned operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod       <= {VALUE_W{1'b0}};
      prod_ind   <= {INDEX_W{1'b0}};
      prod_valid <= 1'b0;
    end else begin
      prod_valid <= load;
      if (load) begin
        prod     <= val * vec_val;
        prod_ind <= ind;
      end
    end
  end

endmodule

// File: rtl/gust_spmv_engine.sv
// Sparse matrix-vector engine: per-lane multiply, then scatter-accumulate into row sums per frame.
module gust_spmv_engine
  import gust_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int ROWS    = DEF_ROWS,
  parameter int VALUE_W = DEF_VALUE_W,
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [LANES*VALUE_W-1:0] val,
  input  logic [LANES*VALUE_W-1:0] vec_val,
  input  logic [LANES*INDEX_W-1:0] ind,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ROWS*VALUE_W-1:0]  ans,
  output logic [CNT_W-1:0]         batch_cnt,
  output logic                     err
);

  state_t             state_r, state_s;
  logic               in_ready_r, in_ready_s;
  logic               accept_s, out_hs_s;
  logic [VALUE_W-1:0] s1_prod [LANES];
  logic [INDEX_W-1:0] s1_ind  [LANES];
  logic [LANES-1:0]   s1_valid;
  logic [LANES-1:0]   dup_s, win_s;
  logic               hit_err_s;
  logic [VALUE_W-1:0] add_s   [ROWS];
  logic [VALUE_W-1:0] acc_r   [ROWS];
  logic [CNT_W-1:0]   cnt_r;
  logic               err_r;

  assign accept_s  = in_valid && in_ready_r;
  assign out_hs_s  = (state_r == ST_OUT) && out_ready;
  assign in_ready  = in_ready_r;
  assign out_valid = (state_r == ST_OUT);
  assign batch_cnt = cnt_r;
  assign err       = err_r;

  // State register; in_ready is registered so it stays low throughout reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      in_ready_r <= in_ready_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (accept_s) state_s = in_last ? ST_DRAIN : ST_ACCUM; else state_s = ST_IDLE;
      ST_ACCUM: if (accept_s && in_last) state_s = ST_DRAIN; else state_s = ST_ACCUM;
      ST_DRAIN: state_s = ST_OUT;
      ST_OUT:   if (out_ready) state_s = ST_IDLE; else state_s = ST_OUT;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Output decode: ready reflects the state being entered.
  always_comb begin
    in_ready_s = 1'b0;
    if (state_s == ST_IDLE || state_s == ST_ACCUM) in_ready_s = 1'b1;
    else in_ready_s = 1'b0;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    gust_lane_mult #(.VALUE_W(VALUE_W), .INDEX_W(INDEX_W)) u_mult (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (accept_s),
      .val        (val[l*VALUE_W +: VALUE_W]),
      .vec_val    (vec_val[l*VALUE_W +: VALUE_W]),
      .ind        (ind[l*INDEX_W +: INDEX_W]),
      .prod       (s1_prod[l]),
      .prod_ind   (s1_ind[l]),
      .prod_valid (s1_valid[l])
    );
  end

  // Lowest lane naming a row wins; later duplicates and out-of-range rows only flag err.
  always_comb begin
    dup_s     = {LANES{1'b0}};
    win_s     = {LANES{1'b0}};
    hit_err_s = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      for (int j = 0; j < l; j++) begin
        if (s1_valid[j] && s1_ind[j] == s1_ind[l]) dup_s[l] = 1'b1;
        else dup_s[l] = dup_s[l];
      end
      if (s1_valid[l] && s1_ind[l] != {INDEX_W{1'b0}}) begin
        if (s1_ind[l] > INDEX_W'(ROWS) || dup_s[l]) hit_err_s = 1'b1;
        else win_s[l] = 1'b1;
      end else begin
        win_s[l] = 1'b0;
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      add_s[r] = {VALUE_W{1'b0}};
      for (int l = 0; l < LANES; l++) begin
        if (win_s[l] && s1_ind[l] == INDEX_W'(r + 1)) add_s[r] = s1_prod[l];
        else add_s[r] = add_s[r];
      end
    end
  end

  // Accumulators, sticky error and saturating batch counter; cleared by the result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) acc_r[r] <= {VALUE_W{1'b0}};
      err_r <= 1'b0;
      cnt_r <= {CNT_W{1'b0}};
    end else if (out_hs_s) begin
      for (int r = 0; r < ROWS; r++) acc_r[r] <= {VALUE_W{1'b0}};
      err_r <= 1'b0;
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      for (int r = 0; r < ROWS; r++) acc_r[r] <= acc_r[r] + add_s[r];
      err_r <= err_r | hit_err_s;
      if (accept_s && cnt_r != {CNT_W{1'b1}}) cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_ans
    assign ans[r*VALUE_W +: VALUE_W] = acc_r[r];
  end

endmodule

// File: doc/gust_spmv_engine.md
GUST_SPMV_ENGINE -- requirements
Module: gust_spmv_engine

Interface
REQ-001 SHALL have parameter LANES, default 16, meaning multiplier lanes per batch.
REQ-002 SHALL have parameter ROWS, default 16, meaning result rows (1..ROWS); ROWS <= 2**INDEX_W - 1.
REQ-003 SHALL have parameter VALUE_W, default 32, meaning two's-complement width of operands, products and sums.
REQ-004 SHALL have parameter INDEX_W, default 5, meaning row-index width per lane.
REQ-005 SHALL have parameter CNT_W, default 8, meaning batch-counter width.
REQ-006 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have port in_valid  input  1  batch presented.
REQ-009 SHALL have port in_ready  output  1  engine accepts batch this cycle.
REQ-010 SHALL have port in_last  input  1  batch is final one of frame.
REQ-011 SHALL have port val  input  LANES*VALUE_W  matrix values, lane i at bits [(i+1)*VALUE_W-1 : i*VALUE_W].
REQ-012 SHALL have port vec_val  input  LANES*VALUE_W  matching vector values.
REQ-013 SHALL have port ind  input  LANES*INDEX_W  target row per lane; 0 = lane empty.
REQ-014 SHALL have port out_valid  output  1  result frame available.
REQ-015 SHALL have port out_ready  input  1  consumer takes result.
REQ-016 SHALL have port ans  output  ROWS*VALUE_W  row sums, row r (1-based) at slot r-1.
REQ-017 SHALL have port batch_cnt  output  CNT_W  batches accepted in current/last frame.
REQ-018 SHALL have port err  output  1  sticky: collision or out-of-range index seen in frame.

Function
REQ-019 SHALL accept a batch on any edge with in_valid && in_ready ("accept edge").
REQ-020 SHALL run FSM IDLE -> ACCUM (first accept, in_last=0) -> DRAIN (accept with in_last=1, from IDLE or ACCUM) -> OUT (one cycle after DRAIN) -> IDLE (out_valid && out_ready).
REQ-021 SHALL drive in_ready=1 only in IDLE and ACCUM; in_ready SHALL not depend on in_valid.
REQ-022 SHALL register per-lane product val*vec_val (low VALUE_W bits, signed) and its index on the accept edge (stage 1).
REQ-023 SHALL add each stage-1 product into acc[ind] on the next edge (stage 2), wrapping modulo 2**VALUE_W.
REQ-024 SHALL treat ind=0 lanes as no-ops and ind>ROWS lanes as dropped with err set.
REQ-025 SHALL, when two or more lanes in one batch name the same row, add only the lowest-numbered lane and set err.
REQ-026 SHALL sustain one batch per cycle in ACCUM, with back-to-back stage-2 updates to the same row correct (no lost update).
REQ-027 SHALL assert out_valid in OUT only, exactly two cycles after the in_last accept edge, with ans = final accumulators, held stable until out_ready.
REQ-028 SHALL, on the out handshake edge, clear all accumulators, err and batch_cnt to 0.
REQ-029 SHALL increment batch_cnt on each accept edge, saturating at 2**CNT_W-1.
REQ-030 SHALL ignore in_valid in DRAIN and OUT (no accept, no state change).

Reset
REQ-031 SHALL on rst_n=0, at any time including mid-frame, force IDLE, accumulators=0, pipeline stage invalid, in_ready=0 while asserted, out_valid=0, ans=0, batch_cnt=0, err=0.
REQ-032 SHALL raise in_ready on the first edge after rst_n deasserts.

Structure
REQ-033 SHALL place FSM state enum and default parameter constants in shared package gust_pkg.
REQ-034 SHALL instantiate one sub-module gust_lane_mult per lane (registered multiply with index and valid pass-through).

Verification
REQ-035 SHALL test single batch, last=1, VALUE_W=32: lanes (val,vec,ind)=(2,3,1),(4,5,2),(-1,7,3) -> ans rows 1..3 = 6,20,-7, others 0, out_valid 2 cycles later, batch_cnt=1, err=0.
REQ-036 SHALL test three back-to-back batches each adding 1*1 to row 4 -> ans row 4 = 3, batch_cnt=3.
REQ-037 SHALL test lanes 0 and 2 both ind=5 with products 10 and 99 -> row 5 = 10, err=1.
REQ-038 SHALL test out_ready held low 5 cycles -> ans and out_valid stable, in_ready=0; then handshake -> accumulators cleared, in_ready=1 next cycle.
REQ-039 SHALL test rst_n pulsed low mid-frame after 2 batches -> all outputs 0; a new 1-batch frame yields only its own sums.
REQ-040 SHALL test overflow 0x7FFFFFFF + 1 into one row -> 0x80000000, err=0.
